// File: rtl/pfa_slice.sv
// WIDTH-bit slice of partial full adder cells: per-bit sum/generate/propagate
// plus group generate/propagate for the next lookahead level.
module pfa_slice #(
    parameter int WIDTH   = 5,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] ci,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] p,
    output logic             grp_g,
    output logic             grp_p
);

    logic [WIDTH-1:0] p_c;
    logic [WIDTH-1:0] g_c;
    logic [WIDTH-1:0] sum_c;
    logic             grp_g_c;
    logic             grp_p_c;

    assign p_c     = a ^ b;
    assign g_c     = a & b;
    assign sum_c   = p_c ^ ci;
    assign grp_p_c = &p_c;

    // Ripple the lookahead expansion from bit 0 upward; no carry-in enters it.
    always_comb begin
        grp_g_c = g_c[0];
        for (int i = 1; i < WIDTH; i++) begin
            grp_g_c = g_c[i] | (p_c[i] & grp_g_c);
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            // Results load every cycle; out_valid alone says whether they mean anything.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    g         <= '0;
                    p         <= '0;
                    grp_g     <= 1'b0;
                    grp_p     <= 1'b0;
                end else begin
                    out_valid <= in_valid;
                    sum       <= sum_c;
                    g         <= g_c;
                    p         <= p_c;
                    grp_g     <= grp_g_c;
                    grp_p     <= grp_p_c;
                end
            end
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign out_valid      = in_valid;
            assign sum            = sum_c;
            assign g              = g_c;
            assign p              = p_c;
            assign grp_g          = grp_g_c;
            assign grp_p          = grp_p_c;
        end
    endgenerate

endmodule

// File: tb/tb_pfa_slice.sv
// Self-checking bench for pfa_slice: registered WIDTH=5 and WIDTH=2 slices plus a
// combinational WIDTH=5 slice, all compared against an arithmetic reference model.
module tb_pfa_slice;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] a = '0;
    logic [4:0] b = '0;
    logic [4:0] ci = '0;

    logic       ov5, gg5, gp5;
    logic [4:0] sum5, g5, p5;
    logic       ov2, gg2, gp2;
    logic [1:0] sum2, g2, p2;
    logic       ovc, ggc, gpc;
    logic [4:0] sumc, gc, pc;

    int checks = 0;
    int errors = 0;

    pfa_slice #(.WIDTH(5), .REG_OUT(1'b1)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .ci(ci),
        .out_valid(ov5), .sum(sum5), .g(g5), .p(p5), .grp_g(gg5), .grp_p(gp5)
    );

    pfa_slice #(.WIDTH(2), .REG_OUT(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a[1:0]), .b(b[1:0]), .ci(ci[1:0]),
        .out_valid(ov2), .sum(sum2), .g(g2), .p(p2), .grp_g(gg2), .grp_p(gp2)
    );

    pfa_slice #(.WIDTH(5), .REG_OUT(1'b0)) dutc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .ci(ci),
        .out_valid(ovc), .sum(sumc), .g(gc), .p(pc), .grp_g(ggc), .grp_p(gpc)
    );

    always #5 clk = ~clk;

    // Group generate is the carry out of a plain w-bit addition with no carry-in;
    // group propagate means every bit position has exactly one operand bit set.
    function automatic void refModel(input int w, input int ra, input int rb, input int rc,
                                     output int es, output int eg, output int ep,
                                     output int egg, output int egp);
        int mask;
        mask = (1 << w) - 1;
        ra   = ra & mask;
        rb   = rb & mask;
        rc   = rc & mask;
        ep   = ra ^ rb;
        eg   = ra & rb;
        es   = ep ^ rc;
        egg  = ((ra + rb) >> w) & 1;
        egp  = (ep == mask) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRegsCleared(input string tag);
        checkOutput({tag, " ov5"}, ov5, 0);
        checkOutput({tag, " sum5"}, sum5, 0);
        checkOutput({tag, " g5"}, g5, 0);
        checkOutput({tag, " p5"}, p5, 0);
        checkOutput({tag, " grp5"}, {gg5, gp5}, 0);
        checkOutput({tag, " ov2"}, ov2, 0);
        checkOutput({tag, " res2"}, {sum2, g2, p2, gg2, gp2}, 0);
    endtask

    task automatic checkComb(input string tag);
        int es, eg, ep, egg, egp;
        refModel(5, a, b, ci, es, eg, ep, egg, egp);
        checkOutput({tag, " comb valid"}, ovc, in_valid);
        checkOutput({tag, " comb sum"}, sumc, es);
        checkOutput({tag, " comb g"}, gc, eg);
        checkOutput({tag, " comb p"}, pc, ep);
        checkOutput({tag, " comb grp"}, {ggc, gpc}, {egg[0], egp[0]});
    endtask

    // Drive one input set at the falling edge, check the combinational slice at
    // once and both registered slices just after the following rising edge.
    task automatic applyStimulus(input string tag, input logic v,
                                 input logic [4:0] ia, input logic [4:0] ib, input logic [4:0] ic);
        int es5, eg5, ep5, egg5, egp5;
        int es2, eg2, ep2, egg2, egp2;
        in_valid = v;
        a        = ia;
        b        = ib;
        ci       = ic;
        refModel(5, ia, ib, ic, es5, eg5, ep5, egg5, egp5);
        refModel(2, ia, ib, ic, es2, eg2, ep2, egg2, egp2);
        #1;
        checkComb(tag);
        @(posedge clk);
        #1;
        checkOutput({tag, " valid5"}, ov5, v);
        checkOutput({tag, " sum5"}, sum5, es5);
        checkOutput({tag, " g5"}, g5, eg5);
        checkOutput({tag, " p5"}, p5, ep5);
        checkOutput({tag, " grp_g5"}, gg5, egg5);
        checkOutput({tag, " grp_p5"}, gp5, egp5);
        checkOutput({tag, " valid2"}, ov2, v);
        checkOutput({tag, " sum2"}, sum2, es2);
        checkOutput({tag, " g2"}, g2, eg2);
        checkOutput({tag, " p2"}, p2, ep2);
        checkOutput({tag, " grp2"}, {gg2, gp2}, {egg2[0], egp2[0]});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Asynchronous reset before the first clock edge, with inputs moving.
        #1;
        rst_n = 1'b0;
        a = 5'($urandom); b = 5'($urandom); ci = 5'($urandom); in_valid = 1'b1;
        #1;
        checkRegsCleared("reset0");
        checkComb("reset0");
        a = 5'($urandom); b = 5'($urandom); ci = 5'($urandom);
        #1;
        checkRegsCleared("reset1");
        checkComb("reset1");

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("idle0", 1'b0, 5'b00000, 5'b00000, 5'b00000);
        applyStimulus("idle1", 1'b0, 5'b00011, 5'b00001, 5'b00000);

        applyStimulus("vecA", 1'b1, 5'b10110, 5'b01101, 5'b00000);
        applyStimulus("vecB", 1'b1, 5'b11111, 5'b00000, 5'b00001);
        applyStimulus("vecC", 1'b1, 5'b11111, 5'b11111, 5'b10101);
        applyStimulus("drain", 1'b0, 5'b01010, 5'b00101, 5'b11000);

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < 4; k++) begin
                    applyStimulus("sweep", 1'b1, 5'(i), 5'(j), 5'(k));
                end
            end
        end

        for (int n = 0; n < 200; n++) begin
            applyStimulus("rand", 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        end

        // Mid-stream reset between clock edges clears a captured result immediately.
        in_valid = 1'b1; a = 5'b11011; b = 5'b01110; ci = 5'b10011;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkRegsCleared("midreset");
        @(negedge clk);
        in_valid = 1'b1; a = 5'b11111; b = 5'b11111; ci = 5'b11111;
        @(posedge clk);
        #1;
        checkRegsCleared("heldreset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("postreset idle", 1'b0, 5'b10001, 5'b01000, 5'b00110);
        applyStimulus("postreset", 1'b1, 5'b10110, 5'b01101, 5'b00000);
        applyStimulus("postreset2", 1'b1, 5'b01111, 5'b10001, 5'b11100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pfa_slice.md
Name: pfa_slice

Overview:
- WIDTH-bit slice of partial full adder (PFA) cells feeding a carry-lookahead network.
- Per bit: sum, bit generate g, bit propagate p. Per slice: group generate/propagate for a higher lookahead level.
- Carries are computed externally and fed back per bit. Outputs are registered: one-cycle latency with a valid strobe.

Parameters:
- WIDTH, 5, number of PFA bit cells (legal 1..16).
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs combinational from inputs, and out_valid equals in_valid.

Ports:
- clk  input  1  single clock; rising edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies a, b, ci this cycle.
- a  input  WIDTH  operand A bits.
- b  input  WIDTH  operand B bits.
- ci  input  WIDTH  per-bit carry-in; ci[i] is the carry into bit i from the external lookahead unit.
- out_valid  output  1  outputs hold a valid result.
- sum  output  WIDTH  per-bit sum.
- g  output  WIDTH  per-bit generate.
- p  output  WIDTH  per-bit propagate.
- grp_g  output  1  group generate of the slice.
- grp_p  output  1  group propagate of the slice.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Per bit i:
  - p[i] = a[i] XOR b[i] (XOR form, not OR).
  - g[i] = a[i] AND b[i].
  - sum[i] = p[i] XOR ci[i].
- Group terms:
  - grp_p = AND of all p[i].
  - grp_g = g[W-1] | p[W-1]&g[W-2] | ... | p[W-1]&...&p[1]&g[0]. This is the standard lookahead expansion and excludes any carry-in.
- No carry is computed internally. Bits are fully independent apart from the group terms.
- REG_OUT=1:
  - On each rising clk, all result outputs load the function of the current a, b, ci.
  - out_valid loads in_valid.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle; no stall or backpressure.
- Result registers load every cycle regardless of in_valid. Consumers must use out_valid to qualify results.
- Reset:
  - rst_n low asynchronously clears out_valid, sum, g, p, grp_g and grp_p to 0, immediately and without waiting for clk.
  - When rst_n deasserts, the first capture occurs at the next rising clk.
  - Reset asserted mid-stream discards the in-flight result; out_valid=0 until a valid input is clocked after release.
- X-free: with all inputs known, all outputs are known. No latches.
- REG_OUT=0: outputs are purely combinational and reset has no effect on them.
- WIDTH=1: grp_g=g[0] and grp_p=p[0].

Test Plan:
- Reset: rst_n=0 with random inputs toggling -> all outputs 0 asynchronously (checked before any clk edge). Release; in_valid=0 -> out_valid stays 0.
- WIDTH=5, a=10110, b=01101, ci=00000, in_valid=1 -> one cycle later: p=11011, g=00100, sum=11011, grp_g=1, grp_p=0, out_valid=1.
- a=11111, b=00000, ci=00001 -> p=11111, g=00000, sum=11110, grp_p=1, grp_g=0.
- a=11111, b=11111, ci=10101 -> g=11111, p=00000, sum=10101, grp_g=1, grp_p=0.
- Back-to-back: valid inputs on 3 consecutive cycles, then in_valid=0 -> 3 consecutive correct results, then out_valid=0. Also exhaustive sweep of a, b, ci for WIDTH=2 against a reference model.
- Assert rst_n low mid-stream between clk edges -> outputs clear immediately. Next valid input after release produces its correct result one cycle later.
